// File: rtl/rnn_mem_pkg.sv
// Shared definitions for the RNN weight/state memory arbiter:
// region-select codes, default widths and FSM state type.
package rnn_mem_pkg;

    localparam int unsigned RNN_AW   = 17;
    localparam int unsigned RNN_DW   = 20;
    localparam int unsigned RNN_SELW = 3;

    localparam logic [RNN_SELW-1:0] SEL_WIH  = 3'b000;
    localparam logic [RNN_SELW-1:0] SEL_BIH  = 3'b001;
    localparam logic [RNN_SELW-1:0] SEL_WHH  = 3'b010;
    localparam logic [RNN_SELW-1:0] SEL_BHH  = 3'b011;
    localparam logic [RNN_SELW-1:0] SEL_TCNT = 3'b100;
    localparam logic [RNN_SELW-1:0] SEL_HOUT = 3'b101;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } arb_state_e;

    // Only the output-h region is written; every other region is read.
    function automatic logic is_write(input logic [RNN_SELW-1:0] sel);
        return sel == SEL_HOUT;
    endfunction

endpackage

// File: rtl/rnn_mem_arbiter_if.sv
// Requester-side and memory-side bus of the RNN memory arbiter.
// slave: the arbiter; master: requesters plus the memory macro.
interface rnn_mem_arbiter_if
    import rnn_mem_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = RNN_AW,
    parameter int unsigned DW   = RNN_DW,
    parameter int unsigned SELW = RNN_SELW
);

    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ*SELW-1:0] req_sel;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DW-1:0]        rdata;
    logic                 mce;
    logic [SELW-1:0]      msel;
    logic [AW-1:0]        maddr;
    logic [DW-1:0]        mdata_w;
    logic [DW-1:0]        mdata_r;

    modport slave (
        input  req, req_lock, req_sel, req_addr, req_wdata, mdata_r,
        output gnt, rvalid, rdata, mce, msel, maddr, mdata_w
    );

    modport master (
        output req, req_lock, req_sel, req_addr, req_wdata, mdata_r,
        input  gnt, rvalid, rdata, mce, msel, maddr, mdata_w
    );

endinterface

// File: rtl/rnn_rr_pick.sv
// Combinational cyclic priority picker: first requesting index at or
// after ptr, wrapping, as one-hot grant plus encoded index.
module rnn_rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          valid
);

    int unsigned   j;
    logic [PW-1:0] j_idx;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        j_idx = '0;
        for (int unsigned off = 0; off < N; off++) begin
            j = 32'(ptr) + off;
            if (j >= N) begin
                j = j - N;
            end
            j_idx = j[PW-1:0];
            if (!valid && req[j_idx]) begin
                valid      = 1'b1;
                gnt[j_idx] = 1'b1;
                idx        = j_idx;
            end
        end
    end

endmodule

// File: rtl/rnn_mem_arbiter.sv
// Round-robin arbiter with burst locking and a starvation cap that owns
// the single RNN weight/state memory port; 2-cycle read latency from gnt.
module rnn_mem_arbiter
    import rnn_mem_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned AW        = RNN_AW,
    parameter int unsigned DW        = RNN_DW,
    parameter int unsigned SELW      = RNN_SELW,
    parameter int unsigned MAX_BURST = 64
) (
    input logic               clk,
    input logic               reset,
    rnn_mem_arbiter_if.slave  bus
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_e      state_q;
    logic [PW-1:0]   owner_q;
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   burst_cnt_q;

    logic            mce_q;
    logic [SELW-1:0] msel_q;
    logic [AW-1:0]   maddr_q;
    logic [DW-1:0]   mdata_w_q;
    logic [NREQ-1:0] rd_issue_q;
    logic [NREQ-1:0] rvalid_q;
    logic [DW-1:0]   rdata_q;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;

    logic [NREQ-1:0] owner_oh;
    logic            others_req;
    logic            do_arb;
    logic [NREQ-1:0] gnt_vec;
    logic [PW-1:0]   gnt_idx;
    logic            any_gnt;
    logic [SELW-1:0] beat_sel;
    logic [AW-1:0]   beat_addr;
    logic [DW-1:0]   beat_wdata;
    logic [PW-1:0]   ptr_next;

    rnn_rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        owner_oh   = NREQ'(1) << owner_q;
        others_req = |(bus.req & ~owner_oh);
        // Arbitrate when idle, when the owner drops req, or when the burst
        // cap is hit while someone else waits (forced rotation).
        do_arb     = (state_q == StIdle) || !bus.req[owner_q] ||
                     ((burst_cnt_q == CW'(MAX_BURST)) && others_req);
        gnt_vec    = owner_oh;
        gnt_idx    = owner_q;
        if (do_arb) begin
            gnt_vec = pick_gnt;
            gnt_idx = pick_idx;
        end
        if (reset) begin
            gnt_vec = '0;
        end
        any_gnt    = |gnt_vec;
        beat_sel   = bus.req_sel[gnt_idx*SELW +: SELW];
        beat_addr  = bus.req_addr[gnt_idx*AW +: AW];
        beat_wdata = bus.req_wdata[gnt_idx*DW +: DW];
        ptr_next   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            ptr_q       <= '0;
            burst_cnt_q <= '0;
            mce_q       <= 1'b0;
            msel_q      <= '0;
            maddr_q     <= '0;
            mdata_w_q   <= '0;
            rd_issue_q  <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
        end else begin
            mce_q <= any_gnt;
            if (any_gnt) begin
                msel_q    <= beat_sel;
                maddr_q   <= beat_addr;
                mdata_w_q <= beat_wdata;
            end
            rd_issue_q <= (any_gnt && !is_write(beat_sel)) ? gnt_vec : '0;
            rvalid_q   <= rd_issue_q;
            if (|rd_issue_q) begin
                rdata_q <= bus.mdata_r;
            end

            if (do_arb) begin
                if (pick_valid) begin
                    ptr_q <= ptr_next;
                    if (bus.req_lock[pick_idx]) begin
                        state_q     <= StLocked;
                        owner_q     <= pick_idx;
                        burst_cnt_q <= CW'(1);
                    end else begin
                        state_q     <= StIdle;
                        burst_cnt_q <= '0;
                    end
                end else begin
                    state_q     <= StIdle;
                    burst_cnt_q <= '0;
                end
            end else if (!bus.req_lock[owner_q]) begin
                state_q     <= StIdle;
                burst_cnt_q <= '0;
            end else if (burst_cnt_q != CW'(MAX_BURST)) begin
                burst_cnt_q <= burst_cnt_q + CW'(1);
            end
        end
    end

    assign bus.gnt     = gnt_vec;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.mce     = mce_q;
    assign bus.msel    = msel_q;
    assign bus.maddr   = maddr_q;
    assign bus.mdata_w = mdata_w_q;

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// Self-checking bench: two arbiters (burst cap 64 and 4) checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_rnn_mem_arbiter;
    import rnn_mem_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rnn_mem_arbiter_if bus_a ();
    rnn_mem_arbiter_if bus_b ();

    rnn_mem_arbiter #(.MAX_BURST(64)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    rnn_mem_arbiter #(.MAX_BURST(4))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic [2:0]  a_req = '0, a_lock = '0, b_req = '0, b_lock = '0;
    logic [8:0]  a_sel = '0, b_sel = '0;
    logic [50:0] a_addr = '0, b_addr = '0;
    logic [59:0] a_wd = '0, b_wd = '0;

    function automatic logic [19:0] mem_fn(input logic [16:0] a);
        return (a == 17'h00021) ? 20'h0ABCD : ({3'b000, a} ^ 20'h5A5A5);
    endfunction

    assign bus_a.req = a_req;   assign bus_a.req_lock = a_lock;  assign bus_a.req_sel = a_sel;
    assign bus_a.req_addr = a_addr;  assign bus_a.req_wdata = a_wd;
    assign bus_a.mdata_r = mem_fn(bus_a.maddr);
    assign bus_b.req = b_req;   assign bus_b.req_lock = b_lock;  assign bus_b.req_sel = b_sel;
    assign bus_b.req_addr = b_addr;  assign bus_b.req_wdata = b_wd;
    assign bus_b.mdata_r = mem_fn(bus_b.maddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: owner (-1 = nobody), pointer, burst length, expected outputs.
    int          m_owner[2] = '{-1, -1};
    int          m_ptr[2]   = '{0, 0};
    int          m_cnt[2]   = '{0, 0};
    logic        e_mce[2]   = '{1'b0, 1'b0};
    logic [2:0]  e_msel[2]  = '{3'b0, 3'b0};
    logic [16:0] e_maddr[2] = '{17'b0, 17'b0};
    logic [19:0] e_wd[2]    = '{20'b0, 20'b0};
    logic [2:0]  e_iss[2]   = '{3'b0, 3'b0};
    logic [16:0] e_iaddr[2] = '{17'b0, 17'b0};
    logic [2:0]  e_rv[2]    = '{3'b0, 3'b0};
    logic [19:0] e_rd[2]    = '{20'b0, 20'b0};

    task automatic model_step(input int k, input int maxb, input logic rst,
                              input logic [2:0] rq, input logic [2:0] lk, input logic [8:0] sl,
                              input logic [50:0] ad, input logic [59:0] wd,
                              input logic [2:0] a_gnt, input logic [2:0] a_rv,
                              input logic [19:0] a_rd, input logic a_mce, input logic [2:0] a_msel,
                              input logic [16:0] a_maddr, input logic [19:0] a_mdw);
        int g, o;
        bit arb;
        logic [2:0] eg;
        g = -1; arb = 1'b1; o = m_owner[k]; eg = '0;
        if (!rst) begin
            if (o >= 0 && rq[o]) begin
                arb = (m_cnt[k] == maxb) && ((rq & ~(3'b001 << o)) != 3'b000);
            end
            if (!arb) g = o;
            else begin
                for (int off = 0; off < 3; off++) begin
                    int j;
                    j = (m_ptr[k] + off) % 3;
                    if (g < 0 && rq[j]) g = j;
                end
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        if (chk_en) begin
            chk($sformatf("m%0d.gnt", k), 32'(a_gnt), 32'(eg));
            chk($sformatf("m%0d.mce", k), 32'(a_mce), 32'(e_mce[k]));
            chk($sformatf("m%0d.msel", k), 32'(a_msel), 32'(e_msel[k]));
            chk($sformatf("m%0d.maddr", k), 32'(a_maddr), 32'(e_maddr[k]));
            chk($sformatf("m%0d.mdata_w", k), 32'(a_mdw), 32'(e_wd[k]));
            chk($sformatf("m%0d.rvalid", k), 32'(a_rv), 32'(e_rv[k]));
            if (e_rv[k] != 3'b000) chk($sformatf("m%0d.rdata", k), 32'(a_rd), 32'(e_rd[k]));
        end
        if (rst) begin
            m_owner[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0;
            e_mce[k] = 1'b0; e_msel[k] = '0; e_maddr[k] = '0; e_wd[k] = '0;
            e_iss[k] = '0; e_iaddr[k] = '0; e_rv[k] = '0; e_rd[k] = '0;
        end else begin
            e_rv[k] = e_iss[k];
            if (e_iss[k] != 3'b000) e_rd[k] = mem_fn(e_iaddr[k]);
            if (g >= 0) begin
                e_mce[k]   = 1'b1;
                e_msel[k]  = sl[g*3 +: 3];
                e_maddr[k] = ad[g*17 +: 17];
                e_wd[k]    = wd[g*20 +: 20];
                e_iss[k]   = (sl[g*3 +: 3] == 3'b101) ? 3'b000 : eg;
                e_iaddr[k] = ad[g*17 +: 17];
            end else begin
                e_mce[k] = 1'b0;
                e_iss[k] = '0;
            end
            if (g < 0) begin
                m_owner[k] = -1; m_cnt[k] = 0;
            end else if (arb) begin
                m_ptr[k] = (g + 1) % 3;
                if (lk[g]) begin m_owner[k] = g; m_cnt[k] = 1; end
                else begin m_owner[k] = -1; m_cnt[k] = 0; end
            end else if (!lk[g]) begin
                m_owner[k] = -1; m_cnt[k] = 0;
            end else if (m_cnt[k] < maxb) begin
                m_cnt[k]++;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 64, reset, a_req, a_lock, a_sel, a_addr, a_wd, bus_a.gnt, bus_a.rvalid,
                   bus_a.rdata, bus_a.mce, bus_a.msel, bus_a.maddr, bus_a.mdata_w);
        model_step(1, 4, reset, b_req, b_lock, b_sel, b_addr, b_wd, bus_b.gnt, bus_b.rvalid,
                   bus_b.rdata, bus_b.mce, bus_b.msel, bus_b.maddr, bus_b.mdata_w);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    logic [2:0] seq2[3] = '{3'b001, 3'b010, 3'b100};
    logic [2:0] seq4[6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};

    initial begin
        cyc();
        chk_en = 1'b1;
        cyc();
        #2 chk("reset.mce", 32'(bus_a.mce), 32'h0);
        chk("reset.rvalid", 32'(bus_a.rvalid), 32'h0);
        cyc();
        reset = 1'b0;

        // Single read from requester 0.
        a_req = 3'b001; a_sel = '0; a_addr[16:0] = 17'h00021;
        #2 chk("t1.gnt", 32'(bus_a.gnt), 32'h1);
        cyc();
        a_req = '0;
        #2 chk("t1.mce", 32'(bus_a.mce), 32'h1);
        chk("t1.maddr", 32'(bus_a.maddr), 32'h00021);
        chk("t1.msel", 32'(bus_a.msel), 32'h0);
        cyc();
        #2 chk("t1.rvalid", 32'(bus_a.rvalid), 32'h1);
        chk("t1.rdata", 32'(bus_a.rdata), 32'h0ABCD);

        // All three requesting, no lock: strict rotation.
        do_reset();
        a_addr = {17'h00102, 17'h00101, 17'h00100};
        a_req = 3'b111;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (i < 6) chk("t2.gnt", 32'(bus_a.gnt), 32'(seq2[i % 3]));
            if (i >= 2) chk("t2.rvalid", 32'(bus_a.rvalid), 32'(seq2[(i - 2) % 3]));
            cyc();
            if (i == 5) a_req = '0;
        end

        // 32-beat locked burst from requester 0 while requester 1 waits.
        do_reset();
        a_req = 3'b011; a_lock = 3'b001;
        for (int b = 1; b <= 32; b++) begin
            a_lock[0] = (b < 32);
            a_addr[16:0] = 17'(17'h00200 + b);
            #2 chk("t3.burst", 32'(bus_a.gnt), 32'h1);
            cyc();
        end
        #2 chk("t3.handover", 32'(bus_a.gnt), 32'h2);
        cyc();
        a_req = '0; a_lock = '0;

        // Burst cap of 4 forces rotation to requester 2.
        do_reset();
        b_req = 3'b001; b_lock = 3'b001;
        b_addr = {17'h00302, 17'h00301, 17'h00300};
        for (int i = 0; i < 6; i++) begin
            if (i == 1) b_req = 3'b101;
            #2 chk("t4.gnt", 32'(bus_b.gnt), 32'(seq4[i]));
            cyc();
            if (i == 4) b_req = 3'b001;
        end
        b_req = '0; b_lock = '0;
        cyc();

        // Write beat from requester 2.
        do_reset();
        a_req = 3'b100; a_sel = {3'b101, 6'b0}; a_addr = {17'h1F03F, 34'b0};
        a_wd = {20'hF0000, 40'b0};
        #2 chk("t5.gnt", 32'(bus_a.gnt), 32'h4);
        cyc();
        a_req = '0;
        #2 chk("t5.mce", 32'(bus_a.mce), 32'h1);
        chk("t5.msel", 32'(bus_a.msel), 32'h5);
        chk("t5.maddr", 32'(bus_a.maddr), 32'h1F03F);
        chk("t5.mdata_w", 32'(bus_a.mdata_w), 32'hF0000);
        cyc();
        #2 chk("t5.rvalid", 32'(bus_a.rvalid), 32'h0);

        // Read in flight when reset hits.
        cyc();
        a_sel = '0; a_addr = {17'h0, 17'h00055, 17'h0};
        a_req = 3'b010;
        #2 chk("t6.gnt", 32'(bus_a.gnt), 32'h2);
        cyc();
        reset = 1'b1; a_req = '0;
        cyc();
        a_req = 3'b111;
        #2 chk("t6.rvalid", 32'(bus_a.rvalid), 32'h0);
        chk("t6.mce", 32'(bus_a.mce), 32'h0);
        chk("t6.maddr", 32'(bus_a.maddr), 32'h0);
        chk("t6.rdata", 32'(bus_a.rdata), 32'h0);
        chk("t6.gnt_in_reset", 32'(bus_a.gnt), 32'h0);
        cyc();
        reset = 1'b0;
        #2 chk("t6.ptr0", 32'(bus_a.gnt), 32'h1);
        cyc();
        a_req = '0;
        cyc();
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
